// File: rtl/uart_seq_pkg.sv
// Shared types and register-map constants for the UART bus sequencer.
// Imported by uart_seq_fifo and uart_bus_sequencer.
package uart_seq_pkg;

    typedef enum logic [2:0] {
        POLL     = 3'd0,
        RX_READ  = 3'd1,
        RX_CLR   = 3'd2,
        TX_LOAD  = 3'd3,
        TX_START = 3'd4,
        TX_WAIT  = 3'd5
    } seq_state_t;

    localparam logic REG_CTRL = 1'b0;
    localparam logic REG_DATA = 1'b1;

    localparam int unsigned CTRL_SEND_BIT  = 0;
    localparam int unsigned CTRL_RXNEW_BIT = 1;

endpackage

// File: rtl/uart_seq_fifo.sv
// Circular transmit FIFO: push/pop with occupancy count; full pushes and empty pops are ignored.
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_seq_fifo
    import uart_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = AW'(0) + (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/uart_bus_sequencer.sv
// Autonomous master for the UART register port: drains a TX FIFO and fetches received bytes.
// Optional TX_WAIT timeout abort is enabled by defining UART_SEQ_TIMEOUT_EN.
module uart_bus_sequencer
    import uart_seq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TX_TIMEOUT = 100000
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [7:0]                    tx_data_i,
    input  logic                          tx_valid_i,
    output logic                          tx_ready_o,
    output logic [7:0]                    rx_data_o,
    output logic                          rx_valid_o,
    output logic [31:0]                   uart_wdata_o,
    output logic                          uart_reg_sel_o,
    output logic                          uart_wr_o,
    input  logic [31:0]                   uart_rdata_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          busy_o,
    output logic                          tx_err_o
);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TX_TIMEOUT < 1)) begin : g_bad_params
        $error("uart_bus_sequencer: FIFO_DEPTH must be a power of two >= 2 and TX_TIMEOUT >= 1");
    end

    seq_state_t state;
    seq_state_t next_state;

    logic       ret_wait;
    logic       tx_inflight;
    logic       clr_inflight;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_head;
    logic       send;
    logic       rxnew;
    logic       unused_rdata_bits;

    assign send              = uart_rdata_i[CTRL_SEND_BIT];
    assign rxnew             = uart_rdata_i[CTRL_RXNEW_BIT];
    assign unused_rdata_bits = ^uart_rdata_i[31:8];

    uart_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk_i),
        .reset     (reset_i),
        .push      (tx_valid_i),
        .push_data (tx_data_i),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count_o),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign tx_ready_o = !fifo_full;
    assign busy_o     = (state != POLL) || !fifo_empty;

`ifdef UART_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TX_TIMEOUT + 1);

    logic [TW-1:0] wait_cnt;
    logic          timeout_hit;

    // Leaving TX_WAIT (including an RX excursion) restarts the count on re-entry.
    always_ff @(posedge clk_i) begin
        if (reset_i || (state != TX_WAIT)) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + TW'(1);
        end
    end

    assign timeout_hit = (wait_cnt == TW'(TX_TIMEOUT - 1));
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= POLL;
            ret_wait    <= 1'b0;
            tx_inflight <= 1'b0;
            rx_data_o   <= '0;
        end else begin
            state <= next_state;
            if ((next_state == RX_READ) && (state != RX_READ)) begin
                ret_wait <= (state == TX_WAIT);
            end
            if (state == RX_READ) begin
                rx_data_o <= uart_rdata_i[7:0];
            end
            if (state == TX_START) begin
                tx_inflight <= 1'b1;
            end else if (clr_inflight) begin
                tx_inflight <= 1'b0;
            end
        end
    end

    always_comb begin
        next_state     = state;
        uart_reg_sel_o = REG_CTRL;
        uart_wr_o      = 1'b0;
        uart_wdata_o   = '0;
        fifo_pop       = 1'b0;
        rx_valid_o     = 1'b0;
        tx_err_o       = 1'b0;
        clr_inflight   = 1'b0;

        case (state)
            POLL: begin
                if (rxnew) begin
                    next_state = RX_READ;
                end else if (!fifo_empty && !send) begin
                    next_state = TX_LOAD;
                end
            end
            RX_READ: begin
                uart_reg_sel_o = REG_DATA;
                next_state     = RX_CLR;
            end
            RX_CLR: begin
                // Rewriting send with the in-flight flag clears rxnew without disturbing a transmission.
                uart_wr_o    = 1'b1;
                uart_wdata_o = {31'b0, tx_inflight};
                rx_valid_o   = 1'b1;
                next_state   = ret_wait ? TX_WAIT : POLL;
            end
            TX_LOAD: begin
                uart_reg_sel_o = REG_DATA;
                uart_wr_o      = 1'b1;
                uart_wdata_o   = {24'b0, fifo_head};
                fifo_pop       = 1'b1;
                next_state     = TX_START;
            end
            TX_START: begin
                uart_wr_o    = 1'b1;
                uart_wdata_o = 32'h1;
                next_state   = TX_WAIT;
            end
            TX_WAIT: begin
                if (rxnew) begin
                    next_state = RX_READ;
                end else if (!send) begin
                    clr_inflight = 1'b1;
                    next_state   = POLL;
                end
`ifdef UART_SEQ_TIMEOUT_EN
                else if (timeout_hit) begin
                    uart_wr_o    = 1'b1;
                    uart_wdata_o = '0;
                    tx_err_o     = 1'b1;
                    clr_inflight = 1'b1;
                    next_state   = POLL;
                end
`endif
            end
            default: begin
                next_state = POLL;
            end
        endcase
    end

endmodule
